// File: rtl/soc_rst_seq_pkg.sv
// Shared types and helpers for the board-level reset sequencer.
// Optional watchdog is enabled with the RST_SEQ_WDT_EN macro (see soc_rst_seq.sv).
package soc_rst_seq_pkg;

  typedef enum logic [1:0] {
    SYS_HOLD = 2'd0,
    CPU_HOLD = 2'd1,
    RUN      = 2'd2
  } rst_state_e;

  typedef enum logic [1:0] {
    POR     = 2'd0,
    SYS_BTN = 2'd1,
    CPU_BTN = 2'd2,
    WDT     = 2'd3
  } rst_cause_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/soc_rst_seq_debounce.sv
// Button debouncer: 2-FF synchroniser followed by a stability filter.
// The stable level flips only after the synchronised level has differed from it for
// DEBOUNCE_CYCLES consecutive edges; shorter glitches are dropped.
// Ports:
//   clk_i     SoC clock
//   rst_ni    asynchronous active-low reset
//   btn_i     raw asynchronous button, active high
//   stable_o  debounced level
module soc_rst_seq_debounce
  import soc_rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/soc_rst_seq.sv
// Board-level reset sequencer: debounces the sys/cpu reset buttons, releases the
// peripheral/I3C reset and then the CPU reset in timed stages, and records the last
// reset cause. All outputs are registered.
// Optional watchdog: define RST_SEQ_WDT_EN to build it (otherwise wdt_kick_i is ignored).
// Ports:
//   clk_i           SoC clock
//   rst_ni          asynchronous active-low reset (PLL locked)
//   btn_sys_i       raw system-reset button, active high
//   btn_cpu_i       raw CPU-reset button, active high
//   wdt_kick_i      watchdog kick pulse
//   periph_rstn_o   peripheral reset, active low
//   i3c_rstn_req_o  I3C reset request, active low, same as periph_rstn_o
//   cpu_rstn_o      CPU reset, active low
//   state_o         current sequencer state
//   rst_cause_o     last reset cause (POR/SYS_BTN/CPU_BTN/WDT)
module soc_rst_seq
  import soc_rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32000,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned WDT_CYCLES      = 1 << 24
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_sys_i,
  input  logic       btn_cpu_i,
  input  logic       wdt_kick_i,
  output logic       periph_rstn_o,
  output logic       i3c_rstn_req_o,
  output logic       cpu_rstn_o,
  output logic [1:0] state_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned GapW = $clog2(STAGE_GAP + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(STAGE_GAP - 1);
  localparam logic [GapW-1:0] GapMax  = GapW'(STAGE_GAP);

  logic sys_stable, cpu_stable;

  soc_rst_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_sys (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_sys_i),
    .stable_o(sys_stable)
  );

  soc_rst_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_cpu (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_cpu_i),
    .stable_o(cpu_stable)
  );

  rst_state_e      state_q, state_d;
  rst_cause_e      cause_q, cause_d;
  logic [GapW-1:0] gap_q, gap_d, gap_inc;
  logic            periph_rstn_q, cpu_rstn_q;
  logic            wdt_expired;

`ifdef RST_SEQ_WDT_EN
  localparam int unsigned WdtW = cnt_width(WDT_CYCLES - 1);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);

  logic [WdtW-1:0] wdt_q, wdt_d;

  // Counts only in RUN; a kick in the same cycle as the last count still saves it.
  always_comb begin
    wdt_d       = '0;
    wdt_expired = 1'b0;
    if (state_q == RUN && !wdt_kick_i) begin
      wdt_d       = wdt_q + WdtW'(1);
      wdt_expired = (wdt_q == WdtLast);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt  = wdt_kick_i ^ (^WDT_CYCLES);
  assign wdt_expired = 1'b0;
`endif

  assign gap_inc = (gap_q == GapMax) ? gap_q : gap_q + GapW'(1);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    gap_d   = gap_inc;
    case (state_q)
      SYS_HOLD: begin
        if (sys_stable) begin
          gap_d = '0;
        end else if (gap_q == GapLast) begin
          state_d = CPU_HOLD;
        end
      end
      CPU_HOLD: begin
        if (sys_stable) begin
          state_d = SYS_HOLD;
          cause_d = SYS_BTN;
        end else if (cpu_stable) begin
          gap_d = '0;
        end else if (gap_q == GapLast) begin
          state_d = RUN;
        end
      end
      RUN: begin
        gap_d = '0;
        if (sys_stable) begin
          state_d = SYS_HOLD;
          cause_d = SYS_BTN;
        end else if (wdt_expired) begin
          state_d = CPU_HOLD;
          cause_d = WDT;
        end else if (cpu_stable) begin
          state_d = CPU_HOLD;
          cause_d = CPU_BTN;
        end
      end
      default: begin
        // Unused encoding: recover to the full-reset stage.
        state_d = SYS_HOLD;
        if (sys_stable) begin
          cause_d = SYS_BTN;
        end
      end
    endcase
    // Every stage starts its gap count from zero.
    if (state_d != state_q) begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SYS_HOLD;
      cause_q       <= POR;
      gap_q         <= '0;
      periph_rstn_q <= 1'b0;
      cpu_rstn_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      gap_q         <= gap_d;
      periph_rstn_q <= (state_d == CPU_HOLD) || (state_d == RUN);
      cpu_rstn_q    <= (state_d == RUN);
    end
  end

  assign periph_rstn_o  = periph_rstn_q;
  assign i3c_rstn_req_o = periph_rstn_q;
  assign cpu_rstn_o     = cpu_rstn_q;
  assign state_o        = state_q;
  assign rst_cause_o    = cause_q;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Self-checking bench for soc_rst_seq: a per-edge reference model pushes expected
// outputs into a queue, and a monitor pops and compares them on the falling edge.
module tb_soc_rst_seq;

  localparam int unsigned DB  = 4;
  localparam int unsigned GAP = 3;
  localparam int unsigned WDC = 20;
`ifdef RST_SEQ_WDT_EN
  localparam bit WdtOn = 1'b1;
`else
  localparam bit WdtOn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       btn_sys_i = 1'b0;
  logic       btn_cpu_i = 1'b0;
  logic       wdt_kick_i = 1'b0;
  logic       periph_rstn_o, i3c_rstn_req_o, cpu_rstn_o;
  logic [1:0] state_o, rst_cause_o;

  always #5 clk_i = ~clk_i;

  soc_rst_seq #(
    .DEBOUNCE_CYCLES(DB),
    .STAGE_GAP      (GAP),
    .WDT_CYCLES     (WDC)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .btn_sys_i     (btn_sys_i),
    .btn_cpu_i     (btn_cpu_i),
    .wdt_kick_i    (wdt_kick_i),
    .periph_rstn_o (periph_rstn_o),
    .i3c_rstn_req_o(i3c_rstn_req_o),
    .cpu_rstn_o    (cpu_rstn_o),
    .state_o       (state_o),
    .rst_cause_o   (rst_cause_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: stages are timed from a reference edge (entry or last hold-off),
  // buttons are accepted once the last DB synchronised samples all disagree.
  int        edge_n = 0;
  int        m_state = 0;
  int        m_cause = 0;
  int        gap_ref = 0;
  int        wdt_ref = 0;
  bit        st_sys = 1'b0;
  bit        st_cpu = 1'b0;
  bit        h_sys[$] = '{1'b0, 1'b0};
  bit        h_cpu[$] = '{1'b0, 1'b0};
  bit        w_sys[$];
  bit        w_cpu[$];
  logic [6:0] exp_q[$];
  int         exp_edge_q[$];

  function automatic bit all_differ(input bit win[$], input bit level);
    if (win.size() < DB) return 1'b0;
    foreach (win[i]) if (win[i] == level) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        edge_n = 0; m_state = 0; m_cause = 0; gap_ref = 0; wdt_ref = 0;
        st_sys = 1'b0; st_cpu = 1'b0;
        h_sys = '{1'b0, 1'b0}; h_cpu = '{1'b0, 1'b0};
        w_sys.delete(); w_cpu.delete();
        exp_q.delete(); exp_edge_q.delete();
      end else begin
        bit syn;
        edge_n++;
        if (m_state == 0) begin
          if (st_sys) gap_ref = edge_n;
          else if (edge_n - gap_ref == GAP) begin m_state = 1; gap_ref = edge_n; end
        end else if (m_state == 1) begin
          if (st_sys) begin m_state = 0; m_cause = 1; gap_ref = edge_n; end
          else if (st_cpu) gap_ref = edge_n;
          else if (edge_n - gap_ref == GAP) begin m_state = 2; wdt_ref = edge_n; end
        end else begin
          if (wdt_kick_i) wdt_ref = edge_n;
          if (st_sys) begin m_state = 0; m_cause = 1; gap_ref = edge_n; end
          else if (WdtOn && (edge_n - wdt_ref == WDC)) begin
            m_state = 1; m_cause = 3; gap_ref = edge_n;
          end else if (st_cpu) begin m_state = 1; m_cause = 2; gap_ref = edge_n; end
        end
        syn = h_sys.pop_front(); h_sys.push_back(btn_sys_i);
        w_sys.push_back(syn); if (w_sys.size() > DB) void'(w_sys.pop_front());
        if (all_differ(w_sys, st_sys)) st_sys = !st_sys;
        syn = h_cpu.pop_front(); h_cpu.push_back(btn_cpu_i);
        w_cpu.push_back(syn); if (w_cpu.size() > DB) void'(w_cpu.pop_front());
        if (all_differ(w_cpu, st_cpu)) st_cpu = !st_cpu;
        exp_q.push_back({2'(m_state), m_state != 0, m_state != 0, m_state == 2, 2'(m_cause)});
        exp_edge_q.push_back(edge_n);
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk_i);
      while (rst_ni && exp_q.size() > 0) begin
        logic [6:0] e, a;
        int         ed;
        e  = exp_q.pop_front();
        ed = exp_edge_q.pop_front();
        a  = {state_o, periph_rstn_o, i3c_rstn_req_o, cpu_rstn_o, rst_cause_o};
        n_total++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard edge=%0d {state,prst,i3c,crst,cause} got=%b expected=%b",
                   ed, a, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (state_o == s) break;
    end
    check("wait_state", state_o, s);
  endtask

  task automatic powerup_check();
    @(negedge clk_i); #2 rst_ni = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk_i); #1;
      check("pwr_periph", {1'b0, periph_rstn_o}, (i >= 3) ? 2'd1 : 2'd0);
      check("pwr_i3c", {1'b0, i3c_rstn_req_o}, (i >= 3) ? 2'd1 : 2'd0);
      check("pwr_cpu", {1'b0, cpu_rstn_o}, (i >= 6) ? 2'd1 : 2'd0);
      check("pwr_state", state_o, (i < 3) ? 2'd0 : (i < 6) ? 2'd1 : 2'd2);
      check("pwr_cause", rst_cause_o, 2'd0);
    end
  endtask

  task automatic press(input bit sys, input bit cpu, input int len);
    @(negedge clk_i);
    btn_sys_i = sys; btn_cpu_i = cpu;
    repeat (len) @(negedge clk_i);
    btn_sys_i = 1'b0; btn_cpu_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_state", state_o, 2'd0);
    check("rst_rstn", {periph_rstn_o, cpu_rstn_o}, 2'b00);
    repeat (3) @(negedge clk_i);
    powerup_check();

    // CPU glitch in RUN is ignored
    press(1'b0, 1'b1, 3);
    repeat (8) @(negedge clk_i);
    check("glitch_state", state_o, 2'd2);
    check("glitch_cpu", {1'b0, cpu_rstn_o}, 2'd1);

    // CPU button held: cpu reset 7 edges after first sampled high
    @(negedge clk_i); btn_cpu_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk_i); #1;
      check("cpu_hold_rstn", {1'b0, cpu_rstn_o}, (i >= 7) ? 2'd0 : 2'd1);
    end
    check("cpu_periph", {1'b0, periph_rstn_o}, 2'd1);
    check("cpu_cause", rst_cause_o, 2'd2);
    repeat (3) @(negedge clk_i);
    btn_cpu_i = 1'b0;
    wait_state(2'd2, 40);

    // Sys button in RUN
    press(1'b1, 1'b0, 10);
    check("sys_state", state_o, 2'd0);
    check("sys_cause", rst_cause_o, 2'd1);
    wait_state(2'd2, 40);

    // Simultaneous press: sys wins
    press(1'b1, 1'b1, 10);
    check("both_state", state_o, 2'd0);
    check("both_cause", rst_cause_o, 2'd1);
    wait_state(2'd2, 40);

    // Watchdog
    if (WdtOn) begin
      for (int i = 1; i <= WDC; i++) begin
        @(posedge clk_i); #1;
        check("wdt_state", state_o, (i < WDC) ? 2'd2 : 2'd1);
      end
      check("wdt_cause", rst_cause_o, 2'd3);
      wait_state(2'd2, 40);
    end
    for (int i = 0; i < 6; i++) begin
      repeat (9) @(negedge clk_i);
      wdt_kick_i = 1'b1;
      @(negedge clk_i);
      wdt_kick_i = 1'b0;
    end
    check("kick_state", state_o, 2'd2);

    // Reset mid-sequence in CPU_HOLD
    @(negedge clk_i); btn_cpu_i = 1'b1;
    wait_state(2'd1, 40);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_state", state_o, 2'd0);
    check("async_rst_rstn", {periph_rstn_o, cpu_rstn_o}, 2'b00);
    check("async_rst_i3c", {1'b0, i3c_rstn_req_o}, 2'd0);
    check("async_rst_cause", rst_cause_o, 2'd0);
    btn_cpu_i = 1'b0;
    repeat (2) @(negedge clk_i);
    powerup_check();

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel <= 2) press(1'b0, 1'b1, $urandom_range(1, 12));
      else if (sel <= 4) press(1'b1, 1'b0, $urandom_range(1, 12));
      else if (sel == 5) press(1'b1, 1'b1, $urandom_range(1, 12));
      else if (sel == 6) begin
        @(negedge clk_i); wdt_kick_i = 1'b1;
        @(negedge clk_i); wdt_kick_i = 1'b0;
      end else if (sel == 7 && it % 5 == 0) begin
        #($urandom_range(1, 8)) rst_ni = 1'b0;
        #1;
        check("rand_rst_state", state_o, 2'd0);
        check("rand_rst_rstn", {periph_rstn_o, cpu_rstn_o}, 2'b00);
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
      end
      repeat ($urandom_range(0, 25)) @(negedge clk_i);
    end

    repeat (5) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
